pio_input_edge_capture: RTL and testbench



---
 rtl/pio_input_edge_capture_if.sv | 26 ++
 rtl/pio_input_edge_capture.sv | 136 +++++++++++++
 tb/tb_pio_input_edge_capture.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_input_edge_capture_if.sv
// Bus bundle for the parallel-input port: the same zero-wait-state
// address/chipselect/write_n/writedata/readdata slave bus used by the
// output PIO. The master drives the strobes; the slave returns readdata.
interface pio_input_edge_capture_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/pio_input_edge_capture.sv
// Parallel-input port with edge capture.
// in_port is synchronized into sync_q, which is readable as DATA. Selected
// edges of sync_q are latched into the write-1-to-clear EDGE_CAP register,
// and irq is raised while any captured bit is enabled in IRQ_MASK.
// Register map: 0 DATA (ro), 1 reserved, 2 IRQ_MASK (rw), 3 EDGE_CAP (w1c).
module pio_input_edge_capture #(
   parameter int unsigned WIDTH       = 11,  // 1..32
   parameter int unsigned EDGE_TYPE   = 0,   // 0 rising, 1 falling, 2 any
   parameter int unsigned SYNC_STAGES = 2    // 2..3
) (
   input  logic                      clk,
   input  logic                      reset_n,
   pio_input_edge_capture_if.slave   bus,
   input  logic [WIDTH-1:0]          in_port,
   output logic                      irq
);

   localparam int unsigned EDGE_RISE = 0;
   localparam int unsigned EDGE_FALL = 1;

   typedef enum logic [1:0] {
      REG_DATA = 2'd0,
      REG_RSVD = 2'd1,
      REG_MASK = 2'd2,
      REG_CAP  = 2'd3
   } reg_addr_e;

   reg_addr_e        addr;
   logic             wr;
   logic [WIDTH-1:0] sync_ff [SYNC_STAGES];
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] cap_clr;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] rd_val;
   logic [31:0]      readdata_ext;
   logic             unused_wdata;

   assign addr = reg_addr_e'(bus.address);
   assign wr   = bus.chipselect & ~bus.write_n;

   // Only writedata[WIDTH-1:0] carries register content; upper bits are ignored.
   assign unused_wdata = ^bus.writedata;

   // Synchronizer chain: in_port -> SYNC_STAGES flops -> sync_q.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the synchronizer is a small flop array, not a RAM, so every
         // stage is reset; otherwise a stale value would leak into DATA and
         // fake an edge after reset.
         for (int i = 0; i < int'(SYNC_STAGES); i++) begin
            sync_ff[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments make every stage sample the value
         // its predecessor held before this edge, giving a true shift chain.
         sync_ff[0] <= in_port;
         for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_ff[i] <= sync_ff[i-1];
         end
      end
   end

   assign sync_q = sync_ff[SYNC_STAGES-1];

   // sync_q delayed by one cycle, the reference for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q <= '0;
      end else begin
         prev_q <= sync_q;
      end
   end

   // Edge detector selected at elaboration by EDGE_TYPE.
   always_comb begin
      // NOTE: a default before the case means every path assigns edge_det,
      // so no latch is inferred for unlisted EDGE_TYPE values.
      edge_det = sync_q ^ prev_q;
      case (EDGE_TYPE)
         EDGE_RISE: edge_det = sync_q & ~prev_q;
         EDGE_FALL: edge_det = ~sync_q & prev_q;
         default:   edge_det = sync_q ^ prev_q;
      endcase
   end

   // Write-1-to-clear mask for EDGE_CAP, active only on a write to address 3.
   always_comb begin
      cap_clr = '0;
      if (wr && addr == REG_CAP) begin
         cap_clr = bus.writedata[WIDTH-1:0];
      end
   end

   // Interrupt mask register, loaded on a write to address 2.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask <= '0;
      end else if (wr && addr == REG_MASK) begin
         irq_mask <= bus.writedata[WIDTH-1:0];
      end
   end

   // Edge capture: clear first, then OR in new edges so a same-cycle edge wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_cap <= '0;
      end else begin
         edge_cap <= (edge_cap & ~cap_clr) | edge_det;
      end
   end

   // Level interrupt straight from the registers; masking never clears EDGE_CAP.
   assign irq = |(edge_cap & irq_mask);

   // Read mux: zero when not selected, zero-extended above WIDTH.
   always_comb begin
      rd_val = '0;
      if (bus.chipselect) begin
         case (addr)
            REG_DATA: rd_val = sync_q;
            REG_RSVD: rd_val = '0;
            REG_MASK: rd_val = irq_mask;
            REG_CAP:  rd_val = edge_cap;
            default:  rd_val = '0;
         endcase
      end
      readdata_ext             = '0;
      readdata_ext[WIDTH-1:0]  = rd_val;
   end

   assign bus.readdata = readdata_ext;

endmodule

// File: tb/tb_pio_input_edge_capture.sv
// Bench for pio_input_edge_capture. One instance per capture mode (rising,
// falling, any) shares the same bus and in_port stimulus. A behavioural
// model keeps a delay line of sampled in_port values plus the mask and
// capture registers per mode; a compare process checks readdata and irq of
// every instance on each falling clock edge, and directed steps pin the
// model with hand-computed literal values.
`timescale 1ns/1ps
module tb_pio_input_edge_capture;

   localparam int WIDTH  = 11;
   localparam int SYNC   = 2;
   localparam int N_MODE = 3;

   logic              clk        = 1'b0;
   logic              reset_n    = 1'b1;
   logic [1:0]        address    = '0;
   logic              chipselect = 1'b0;
   logic              write_n    = 1'b1;
   logic [31:0]       writedata  = '0;
   logic [WIDTH-1:0]  in_port    = '0;
   logic [31:0]       rd [N_MODE];
   logic [N_MODE-1:0] irq_w;

   int n_checks = 0;
   int n_fail   = 0;

   always #10 clk = ~clk;

   for (genvar g = 0; g < N_MODE; g++) begin : g_dut
      pio_input_edge_capture_if bus ();
      assign bus.address    = address;
      assign bus.chipselect = chipselect;
      assign bus.write_n    = write_n;
      assign bus.writedata  = writedata;
      assign rd[g]          = bus.readdata;

      pio_input_edge_capture #(
         .WIDTH       (WIDTH),
         .EDGE_TYPE   (g),
         .SYNC_STAGES (SYNC)
      ) u_dut (
         .clk     (clk),
         .reset_n (reset_n),
         .bus     (bus),
         .in_port (in_port),
         .irq     (irq_w[g])
      );
   end

   // ---------------- behavioural model ----------------
   // m_hist[0] is the newest sampled in_port; DATA is SYNC samples old and
   // the edge reference one sample older still.
   logic [WIDTH-1:0] m_hist [$];
   logic [WIDTH-1:0] m_mask [N_MODE];
   logic [WIDTH-1:0] m_cap  [N_MODE];

   function automatic logic [WIDTH-1:0] m_edge(input int mode,
                                               input logic [WIDTH-1:0] cur,
                                               input logic [WIDTH-1:0] prv);
      case (mode)
         0:       return cur & ~prv;
         1:       return ~cur & prv;
         default: return cur ^ prv;
      endcase
   endfunction

   function automatic logic [31:0] m_read(input int mode);
      if (!chipselect) return 32'h0;
      case (address)
         2'd0:    return 32'(m_hist[SYNC-1]);
         2'd2:    return 32'(m_mask[mode]);
         2'd3:    return 32'(m_cap[mode]);
         default: return 32'h0;
      endcase
   endfunction

   task automatic m_clear();
      m_hist = {};
      for (int i = 0; i <= SYNC; i++) m_hist.push_back('0);
      for (int m = 0; m < N_MODE; m++) begin
         m_mask[m] = '0;
         m_cap[m]  = '0;
      end
   endtask

   initial begin : model
      logic             wr;
      logic [WIDTH-1:0] clr;
      m_clear();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            m_clear();
         end else begin
            wr  = chipselect && !write_n;
            clr = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
            for (int m = 0; m < N_MODE; m++) begin
               m_cap[m] = (m_cap[m] & ~clr) | m_edge(m, m_hist[SYNC-1], m_hist[SYNC]);
               if (wr && address == 2'd2) m_mask[m] = writedata[WIDTH-1:0];
            end
            m_hist.push_front(in_port);
            void'(m_hist.pop_back());
         end
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin : compare
      forever begin
         @(negedge clk);
         for (int m = 0; m < N_MODE; m++) begin
            check($sformatf("model_rd_mode%0d_addr%0d", m, address), rd[m], m_read(m));
            check($sformatf("model_irq_mode%0d", m), 32'(irq_w[m]),
                  32'(|(m_cap[m] & m_mask[m])));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   // Advance n rising edges and land 1 ns after the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      step(1);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic read_chk(input string name, input logic [1:0] a,
                           input int mode, input logic [31:0] exp);
      chipselect = 1'b1;
      write_n    = 1'b1;
      address    = a;
      #1;
      check(name, rd[mode], exp);
   endtask

   task automatic irq_chk(input string name, input int mode, input logic exp);
      check(name, 32'(irq_w[mode]), 32'(exp));
   endtask

   // ---------------- directed sequence ----------------
   initial begin : stimulus
      // Reset with all inputs high.
      #1;
      reset_n = 1'b0;
      in_port = 11'h7FF;
      step(2);
      read_chk("rst_data",     2'd0, 0, 32'h0);
      read_chk("rst_mask",     2'd2, 0, 32'h0);
      read_chk("rst_cap_rise", 2'd3, 0, 32'h0);
      read_chk("rst_cap_any",  2'd3, 2, 32'h0);
      irq_chk("rst_irq", 0, 1'b0);
      reset_n = 1'b1;
      step(1);
      read_chk("rel_data_1", 2'd0, 0, 32'h0);
      step(1);
      read_chk("rel_data_2", 2'd0, 0, 32'h7FF);
      read_chk("rel_cap_2",  2'd3, 0, 32'h0);
      step(1);
      read_chk("rel_cap_rise", 2'd3, 0, 32'h7FF);
      read_chk("rel_cap_fall", 2'd3, 1, 32'h0);
      read_chk("rel_cap_any",  2'd3, 2, 32'h7FF);

      // Return inputs low, then clear every capture.
      in_port = '0;
      step(4);
      bus_write(2'd3, 32'h7FF);
      read_chk("init_clr_rise", 2'd3, 0, 32'h0);
      read_chk("init_clr_fall", 2'd3, 1, 32'h0);

      // Edge on bit 2 with bit 2 unmasked.
      bus_write(2'd2, 32'h004);
      in_port = 11'h004;
      step(2);
      read_chk("e2_data_k1", 2'd0, 0, 32'h004);
      irq_chk("e2_irq_k1", 0, 1'b0);
      step(1);
      irq_chk("e2_irq_k2_rise", 0, 1'b1);
      irq_chk("e2_irq_k2_fall", 1, 1'b0);
      irq_chk("e2_irq_k2_any",  2, 1'b1);
      read_chk("e2_cap_rise", 2'd3, 0, 32'h004);
      bus_write(2'd3, 32'h004);
      irq_chk("e2_irq_clr_rise", 0, 1'b0);
      irq_chk("e2_irq_clr_any",  2, 1'b0);

      // Clear bit 0 in the very cycle its edge is captured: set wins.
      in_port = 11'h005;
      step(2);
      bus_write(2'd3, 32'h001);
      read_chk("coll_cap_rise", 2'd3, 0, 32'h001);
      read_chk("coll_cap_fall", 2'd3, 1, 32'h0);
      read_chk("coll_cap_any",  2'd3, 2, 32'h001);

      // Falling edge on bit 0.
      in_port = 11'h001;
      step(4);
      bus_write(2'd3, 32'h7FF);
      in_port = 11'h000;
      step(3);
      read_chk("fall_cap_fall", 2'd3, 1, 32'h001);
      read_chk("fall_cap_rise", 2'd3, 0, 32'h0);
      read_chk("fall_cap_any",  2'd3, 2, 32'h001);

      // Three-cycle pulse on bit 1.
      bus_write(2'd3, 32'h7FF);
      in_port = 11'h002;
      step(3);
      read_chk("pulse_any_mid",  2'd3, 2, 32'h002);
      read_chk("pulse_fall_mid", 2'd3, 1, 32'h0);
      in_port = 11'h000;
      step(4);
      read_chk("pulse_any_end",  2'd3, 2, 32'h002);
      read_chk("pulse_fall_end", 2'd3, 1, 32'h002);
      read_chk("pulse_rise_end", 2'd3, 0, 32'h002);

      // Bus hygiene: IRQ_MASK currently 0x004.
      bus_write(2'd0, 32'h7FF);
      bus_write(2'd1, 32'h7FF);
      chipselect = 1'b0;
      write_n    = 1'b0;
      address    = 2'd2;
      writedata  = 32'h7FF;
      step(1);
      write_n   = 1'b1;
      writedata = '0;
      #1;
      check("hyg_nocs_rd", rd[0], 32'h0);
      read_chk("hyg_mask_kept", 2'd2, 0, 32'h004);
      read_chk("hyg_rsvd",      2'd1, 0, 32'h0);
      read_chk("hyg_data",      2'd0, 0, 32'h0);
      bus_write(2'd2, 32'hFFFF_F800);
      read_chk("hyg_mask_hi", 2'd2, 0, 32'h0);
      read_chk("hyg_cap_any", 2'd3, 2, 32'h002);

      // Async reset in the middle of a cycle.
      bus_write(2'd3, 32'h7FF);
      in_port = 11'h3FF;
      step(3);
      bus_write(2'd2, 32'h3FF);
      irq_chk("ar_irq_before", 0, 1'b1);
      read_chk("ar_cap_before", 2'd3, 0, 32'h3FF);
      reset_n = 1'b0;
      #1;
      irq_chk("ar_irq_rise", 0, 1'b0);
      irq_chk("ar_irq_any",  2, 1'b0);
      read_chk("ar_cap",  2'd3, 0, 32'h0);
      read_chk("ar_mask", 2'd2, 0, 32'h0);
      read_chk("ar_data", 2'd0, 0, 32'h0);
      read_chk("ar_cap_any", 2'd3, 2, 32'h0);
      step(2);
      reset_n = 1'b1;
      in_port = '0;
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
